p160_p161_pipe: RTL and testbench



---
 rtl/posit16_pkg.sv | 20 ++
 rtl/p160_decode.sv | 39 +++
 rtl/p160_p161_pipe.sv | 96 +++++++++
 tb/tb_p160_p161_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/posit16_pkg.sv
// Shared constants and decoded-field type for 16-bit posit converters.
package posit16_pkg;

  localparam int P16_N       = 16;
  localparam int P160_FRAC_W = 12;
  localparam int P161_FRAC_W = 13;

  localparam logic [15:0] P16_ZERO = 16'h0000;
  localparam logic [15:0] P16_NAR  = 16'h8000;

  // Decoded posit: scale is the combined regime/exponent value (signed).
  typedef struct packed {
    logic                   sign;
    logic                   is_zero;
    logic                   is_nar;
    logic signed [4:0]      scale;
    logic [P160_FRAC_W-1:0] frac;
  } p16_dec_t;

endpackage

// File: rtl/p160_decode.sv
// Combinational posit<16,0> regime decoder: magnitude in, decoded fields out.
module p160_decode
  import posit16_pkg::*;
(
  input  logic        i_sign,
  input  logic [15:0] i_mag,
  output p16_dec_t    o_dec
);

  logic [14:0] w_body;
  logic        w_r;
  logic [3:0]  w_run;
  logic        w_stop;
  logic [4:0]  w_lead;

  // Count the regime run, then strip regime + terminator to left-align the fraction.
  always_comb begin
    w_body = i_mag[14:0];
    w_r    = w_body[14];
    w_run  = 4'd0;
    w_stop = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (!w_stop) begin
        if (w_body[i] == w_r) w_run = w_run + 4'd1;
        else                  w_stop = 1'b1;
      end
    end
    // A run of 15 ones has no terminator; the shift by 16 leaves frac = 0.
    w_lead        = {1'b0, w_run} + 5'd1;
    o_dec.sign    = i_sign;
    o_dec.is_zero = (i_mag == P16_ZERO);
    // Two's complement of 0x8000 is itself, so NaR shows up as this magnitude.
    o_dec.is_nar  = (i_mag == P16_NAR);
    o_dec.scale   = w_r ? ({1'b0, w_run} - 5'd1) : (5'd0 - {1'b0, w_run});
    // At scale 0 and -1 a p160 carries 13 fraction bits; only the top 12 are kept.
    o_dec.frac    = 12'((w_body << w_lead) >> 3);
  end

endmodule

// File: rtl/p160_p161_pipe.sv
// Two-stage posit<16,0> -> posit<16,1> converter with valid/ready on both sides.
module p160_p161_pipe
  import posit16_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_p160,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_p161,
  output logic         busy
);

  logic [15:0]       w_mag;
  p16_dec_t          w_dec;
  p16_dec_t          r_s1;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic [15:0]       r_out;
  logic              w_s2_load;

  logic signed [4:0] w_k1;
  logic [3:0]        w_nk;
  logic              w_e;
  logic [3:0]        w_rlen;
  logic [14:0]       w_reg;
  logic [14:0]       w_body;
  logic [15:0]       w_enc;

  assign w_mag = in_p160[15] ? (~in_p160 + 16'd1) : in_p160;

  p160_decode u_dec (
    .i_sign (in_p160[15]),
    .i_mag  (w_mag),
    .o_dec  (w_dec)
  );

  // Stage 2 can take new data when empty or draining; stage 1 follows.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

  assign out_valid = r_s2_valid;
  assign out_p161  = r_out;
  assign busy      = r_s1_valid || r_s2_valid;

  // Stage 1: capture decoded fields on the input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_dec;
    end
  end

  // Encode: split scale into regime k1 and one exponent bit, then pack the body.
  always_comb begin
    w_k1   = $signed(r_s1.scale) >>> 1;
    w_e    = r_s1.scale[0];
    w_nk   = 4'(5'd0 - w_k1);
    w_rlen = 4'd0;
    w_reg  = 15'd0;
    if (!w_k1[4]) begin
      // (k1+1) ones then a zero, top-aligned
      w_rlen = w_k1[3:0] + 4'd2;
      w_reg  = ~(15'h7FFF >> ({1'b0, w_k1[3:0]} + 5'd1));
    end else begin
      // (-k1) zeros then a one
      w_rlen = w_nk + 4'd1;
      w_reg  = 15'h4000 >> w_nk;
    end
    // |k1| <= 7 leaves room for all 12 fraction bits; only zero padding is shifted out.
    w_body = w_reg | ({w_e, r_s1.frac, 2'b00} >> w_rlen);
    if (r_s1.is_zero)     w_enc = P16_ZERO;
    else if (r_s1.is_nar) w_enc = P16_NAR;
    else if (r_s1.sign)   w_enc = ~{1'b0, w_body} + 16'd1;
    else                  w_enc = {1'b0, w_body};
  end

  // Stage 2: output register, held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out      <= P16_ZERO;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_out <= w_enc;
    end
  end

endmodule

// File: tb/tb_p160_p161_pipe.sv
// Directed and streamed checks for the p160 -> p161 converter.
module tb_p160_p161_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_p160;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p161;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rx    = 0;
  bit          busy_chk = 1'b0;
  logic [15:0] sbq[$];

  p160_p161_pipe #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p160   (in_p160),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p161  (out_p161),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the p160 bits to (k, frac), then emit the p161 bit string.
  function automatic logic [15:0] ref_conv(input logic [15:0] x);
    logic [15:0] m;
    logic [14:0] body;
    logic [11:0] fr;
    logic [31:0] acc;
    logic        r;
    int          i, n, k, k1, e, len;
    if (x == 16'h0000 || x == 16'h8000) return x;
    m = x[15] ? (~x + 16'd1) : x;
    r = m[14];
    i = 14;
    n = 0;
    while (i >= 0 && m[i] == r) begin n++; i--; end
    k = r ? n - 1 : -n;
    i--;
    fr = 12'd0;
    for (int j = 0; j < 12; j++) begin
      fr = {fr[10:0], (i >= 0) ? m[i] : 1'b0};
      i--;
    end
    k1  = (k >= 0) ? k / 2 : -((1 - k) / 2);
    e   = k - 2 * k1;
    acc = 32'd0;
    len = 0;
    if (k1 >= 0) begin
      for (int j = 0; j < k1 + 1; j++) begin acc = {acc[30:0], 1'b1}; len++; end
      acc = {acc[30:0], 1'b0}; len++;
    end else begin
      for (int j = 0; j < -k1; j++) begin acc = {acc[30:0], 1'b0}; len++; end
      acc = {acc[30:0], 1'b1}; len++;
    end
    acc = {acc[30:0], e[0]}; len++;
    for (int j = 11; j >= 0; j--) begin acc = {acc[30:0], fr[j]}; len++; end
    body = 15'(acc >> (len - 15));
    return x[15] ? (~{1'b0, body} + 16'd1) : {1'b0, body};
  endfunction

  // Scoreboard on handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_chk) check("busy", 32'(busy), 32'(sbq.size() != 0));
      if (out_valid && out_ready) begin
        if (sbq.size() != 0) check("stream", 32'(out_p161), 32'(sbq.pop_front()));
        else                 check("stream_extra", 32'(out_p161), 32'hxxxx);
        n_rx++;
      end
      if (in_valid && in_ready) sbq.push_back(ref_conv(in_p160));
    end
  end

  // Single transfer: nothing after 1 cycle, result after exactly 2.
  task automatic single(input string tag, input logic [15:0] x, input logic [15:0] exp);
    in_p160   = x;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_vld", 32'(out_valid), 32'd1);
    check(tag, 32'(out_p161), 32'(exp));
    @(posedge clk); #1;
  endtask

  // 0x4001 is 1+2^-13; p161 keeps 12 fraction bits at scale 0, so the LSB truncates.
  logic [15:0] vin [10] = '{16'h4000, 16'h6000, 16'h5000, 16'h4001, 16'hC000,
                             16'h7FFF, 16'h0001, 16'h8001, 16'h0000, 16'h8000};
  logic [15:0] vexp[10] = '{16'h4000, 16'h5000, 16'h4800, 16'h4000, 16'hC000,
                             16'h7F80, 16'h0080, 16'h8080, 16'h0000, 16'h8000};

  initial begin
    int  rx0;
    bit  found;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_p160   = 16'h0000;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p161",  32'(out_p161),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 10; v++) single("vec", vin[v], vexp[v]);

    // Back-pressure: 0x4800 (1.25) -> 0x4400 sits in the output while stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_p160   = 16'h4800;
    check("bp_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_p160 = 16'h3000;
    check("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_p160 = 16'hB000;
    for (int c = 0; c < 5; c++) begin
      check("bp_stall_rdy", 32'(in_ready),  32'd0);
      check("bp_vld",       32'(out_valid), 32'd1);
      check("bp_hold",      32'(out_p161),  32'h4400);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy_rise", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("bp_nogap", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      if (c == 0) in_valid = 1'b0;
    end
    check("bp_empty", 32'(busy), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_p160   = 16'h1234;
    @(posedge clk); #1;
    in_p160 = 16'h2345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_vld", 32'(out_valid), 32'd1);
    check("full_rdy", 32'(in_ready),  32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_vld",  32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy),      32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_p160   = 16'h5A5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (out_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("arst_seen",  32'(found),    32'd1);
    check("arst_first", 32'(out_p161), 32'(ref_conv(16'h5A5A)));
    @(posedge clk); #1;

    // Exhaustive, back-to-back: 65536 outputs in 65536+2 cycles means no gaps.
    rx0       = n_rx;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int v = 0; v < 65536; v++) begin
      in_p160 = 16'(v);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("exh_count", 32'(n_rx - rx0), 32'd65536);

    // Random valid/ready with busy tracking.
    busy_chk = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_p160   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    busy_chk = 1'b0;
    check("drain_queue", 32'(sbq.size()), 32'd0);
    check("drain_busy",  32'(busy),       32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
